alu_share_ctrl: RTL and testbench

// - Sequences the single 16-bit ALU and shares it between NUM_REQ requesters (e.g. EX stage, debug/self-test port).
// - Round-robin arbitration, operand/opcode issue registers, registered result, and the architectural Z/V/N flag register.
// - Sits between requesters and the combinational ALU; the ALU is instantiated outside this block.

---
 rtl/alu_share_ctrl_pkg.sv | 44 ++++
 rtl/alu_share_ctrl_rr_arbiter.sv | 48 ++++
 rtl/alu_share_ctrl.sv | 128 ++++++++++++
 tb/tb_alu_share_ctrl.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// Shared types for the ALU sharing controller.
// Opcodes, FSM states, flag positions and flag-update rules.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LHB    = 4'hA,
    OP_LLB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_HLT    = 4'hE,
    OP_PCS    = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_e;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  function automatic logic updates_vn(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic updates_z(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_XOR) || (op == OP_SLL) ||
           (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after last winner.
// Pointer holds the highest-priority index and moves only on accept.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] jj;
  logic          found;
  int            j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    jj        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j  = (int'(ptr_q) + k) % NUM_REQ;
      jj = IW'(j);
      if (!found && req[jj]) begin
        found     = 1'b1;
        grant[jj] = en;
        grant_idx = jj;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = IW'((int'(grant_idx) + 1) % NUM_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between NUM_REQ requesters.
// IDLE -> EXEC -> RESP; holds issue, result and Z/V/N flag registers.
module alu_share_ctrl #(
  parameter int NUM_REQ = 2,
  parameter int DW      = 16,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [4*NUM_REQ-1:0]  req_op,
  input  logic [DW*NUM_REQ-1:0] req_a,
  input  logic [DW*NUM_REQ-1:0] req_b,
  output logic                  resp_valid,
  output logic [IW-1:0]         resp_id,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic [DW-1:0]         resp_result,
  output logic [DW-1:0]         alu_a,
  output logic [DW-1:0]         alu_b,
  output logic [3:0]            alu_op,
  input  logic [DW-1:0]         alu_result,
  input  logic                  alu_pos_ovfl,
  input  logic                  alu_neg_ovfl,
  output logic [2:0]            flags
);

  import alu_ctrl_pkg::*;

  state_e        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] res_q, res_d;
  logic [IW-1:0] id_q, id_d;
  logic [2:0]    flags_q, flags_d;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      gidx;
  logic               arb_en;
  logic               accept;

  // Grants are suppressed while reset is asserted
  assign arb_en = (state_q == S_IDLE) && !rst;
  assign accept = |(req_valid & grant);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .en        (arb_en),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (gidx)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    id_d    = id_q;
    flags_d = flags_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          for (int k = 0; k < NUM_REQ; k++) begin
            if (gidx == IW'(k)) begin
              op_d = req_op[k*4 +: 4];
              a_d  = req_a[k*DW +: DW];
              b_d  = req_b[k*DW +: DW];
            end
          end
          id_d    = gidx;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d = alu_result;
        if (updates_z(op_q))
          flags_d[FLAG_Z] = (alu_result == '0);
        if (updates_vn(op_q)) begin
          flags_d[FLAG_V] = alu_pos_ovfl | alu_neg_ovfl;
          flags_d[FLAG_N] = alu_result[DW-1];
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready[id_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      id_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      id_q    <= id_d;
      flags_q <= flags_d;
    end
  end

  assign req_ready   = grant;
  assign resp_valid  = (state_q == S_RESP);
  assign resp_id     = id_q;
  assign resp_result = res_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign flags       = flags_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with a behavioural ALU,
// round-robin and flag reference model.
module tb_alu_share_ctrl;

  localparam int N  = 2;
  localparam int DW = 16;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [4*N-1:0]  req_op;
  logic [DW*N-1:0] req_a;
  logic [DW*N-1:0] req_b;
  logic            resp_valid;
  logic            resp_id;
  logic [N-1:0]    resp_ready;
  logic [DW-1:0]   resp_result;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic [3:0]      alu_op;
  logic [DW-1:0]   alu_result;
  logic            alu_pos_ovfl;
  logic            alu_neg_ovfl;
  logic [2:0]      flags;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0]  mflags;
  int          mlast;
  logic [3:0]  m_op [N];
  logic [15:0] m_a  [N];
  logic [15:0] m_b  [N];

  alu_share_ctrl #(.NUM_REQ(N), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_ready   (resp_ready),
    .resp_result  (resp_result),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_pos_ovfl (alu_pos_ovfl),
    .alu_neg_ovfl (alu_neg_ovfl),
    .flags        (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pos_ovfl, neg_ovfl, result}
  function automatic logic [17:0] alu_fn(
    input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        p, n;
    p = 1'b0;
    n = 1'b0;
    case (op)
      4'h0: begin
        r = a + b;
        p = !a[15] && !b[15] && r[15];
        n = a[15] && b[15] && !r[15];
      end
      4'h1: begin
        r = a - b;
        p = !a[15] && b[15] && r[15];
        n = a[15] && !b[15] && !r[15];
      end
      4'h2: r = a ^ b;
      4'h4: r = a << b[3:0];
      4'h5: r = $signed(a) >>> b[3:0];
      4'h6: r = (a >> b[3:0]) | (a << (16 - int'(b[3:0])));
      4'hA: r = {b[7:0], a[7:0]};
      4'hB: r = {a[15:8], b[7:0]};
      default: r = a | b;
    endcase
    return {p, n, r};
  endfunction

  always_comb {alu_pos_ovfl, alu_neg_ovfl, alu_result} = alu_fn(alu_op, alu_a, alu_b);

  function automatic int rr_pick(input logic [1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [2:0] flag_rule(
    input logic [2:0] f, input logic [3:0] op, input logic [17:0] r);
    if (op == 4'h0 || op == 4'h1)
      return {r[15:0] == 16'h0, r[17] | r[16], r[15]};
    if (op == 4'h2 || op == 4'h4 || op == 4'h5 || op == 4'h6)
      return {r[15:0] == 16'h0, f[1:0]};
    return f;
  endfunction

  task automatic set_req(input int r, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b);
    m_op[r] = op;
    m_a[r]  = a;
    m_b[r]  = b;
    req_op[4*r +: 4] = op;
    req_a[16*r +: 16] = a;
    req_b[16*r +: 16] = b;
  endtask

  task automatic send(input logic [1:0] v, input bit hold,
                      output int g, output logic [1:0] rdy, output bit to);
    g   = -1;
    rdy = 'x;
    to  = 1'b0;
    @(negedge clk);
    req_valid = v;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (|(req_ready & req_valid)) begin
        rdy = req_ready;
        g   = req_ready[1] ? 1 : 0;
        break;
      end
      @(negedge clk);
    end
    if (g < 0) to = 1'b1;
    else begin
      @(posedge clk);
      #1;
      if (!hold) req_valid = '0;
    end
  endtask

  task automatic recv(input int dly, output int id, output logic [15:0] res,
                      output logic [2:0] fl, output int lat,
                      output bit to, output bit stable);
    bit found;
    found  = 1'b0;
    to     = 1'b0;
    stable = 1'b1;
    lat    = 0;
    id     = -1;
    res    = 'x;
    fl     = 'x;
    resp_ready = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        found = 1'b1;
        lat   = c;
        break;
      end
    end
    if (!found) begin
      to = 1'b1;
      return;
    end
    id  = int'(resp_id);
    res = resp_result;
    fl  = flags;
    if (dly > 0) resp_ready = 2'b11 ^ (2'b01 << id);
    for (int d = 0; d < dly; d++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || int'(resp_id) != id ||
          resp_result !== res || req_ready !== 2'b00)
        stable = 1'b0;
    end
    resp_ready = 2'b01 << id;
    @(posedge clk);
    #1;
    resp_ready = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 2'b11;
    set_req(0, 4'h0, 16'h1111, 16'h2222);
    set_req(1, 4'h1, 16'h3333, 16'h4444);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b want 00", req_ready);
    end
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid);
    end
    n_checks++;
    if (flags !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", flags);
    end
    n_checks++;
    if (resp_result !== 16'h0 || resp_id !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_resp: got %h/%b want 0000/0", resp_result, resp_id);
    end
    mflags = 3'b000;
    mlast  = N - 1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== (2'b01 << rr_pick(2'b11, mlast))) begin
      n_fail++; $display("FAIL reset_first_grant: got %b want 01", req_ready);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_add;
    int g, id, lat;
    logic [1:0] rdy;
    logic [15:0] res;
    logic [2:0] fl;
    bit to, st;
    set_req(0, 4'h0, 16'h7FFF, 16'h0001);
    send(2'b01, 1'b0, g, rdy, to);
    n_checks++;
    if (to || g !== 0) begin
      n_fail++; $display("FAIL add_grant: got %0d (timeout %0d) want 0", g, to);
    end
    recv(0, id, res, fl, lat, to, st);
    n_checks++;
    if (to || lat !== 2) begin
      n_fail++; $display("FAIL add_latency: got %0d want 2", lat);
    end
    n_checks++;
    if (id !== 0 || res !== 16'h8000) begin
      n_fail++; $display("FAIL add_result: got id %0d %h want 0 8000", id, res);
    end
    n_checks++;
    if (fl !== 3'b011) begin
      n_fail++; $display("FAIL add_flags: got %b want 011", fl);
    end
    mflags = 3'b011;
    mlast  = 0;
  endtask

  task automatic test_flag_hold;
    int g, id, lat;
    logic [1:0] rdy;
    logic [15:0] res;
    logic [2:0] fl;
    bit to, st;
    set_req(1, 4'h2, 16'h1234, 16'h1234);
    send(2'b10, 1'b0, g, rdy, to);
    recv(0, id, res, fl, lat, to, st);
    n_checks++;
    if (g !== 1 || id !== 1 || res !== 16'h0000) begin
      n_fail++;
      $display("FAIL xor_result: got g%0d id%0d %h want 1 1 0000", g, id, res);
    end
    n_checks++;
    if (fl !== 3'b111) begin
      n_fail++; $display("FAIL xor_flags: got %b want 111", fl);
    end
    set_req(0, 4'hB, 16'hABCD, 16'h0055);
    send(2'b01, 1'b0, g, rdy, to);
    recv(0, id, res, fl, lat, to, st);
    n_checks++;
    if (g !== 0 || res !== 16'hAB55) begin
      n_fail++; $display("FAIL llb_result: got g%0d %h want 0 ab55", g, res);
    end
    n_checks++;
    if (fl !== 3'b111) begin
      n_fail++; $display("FAIL llb_flags: got %b want 111", fl);
    end
    mflags = 3'b111;
    mlast  = 0;
  endtask

  task automatic test_arbitration;
    int g, id, lat, eg;
    logic [1:0] rdy;
    logic [15:0] res;
    logic [2:0] fl;
    logic [17:0] r;
    bit to, st;
    set_req(0, 4'h1, 16'h0010, 16'h0003);
    set_req(1, 4'h0, 16'h8000, 16'h8000);
    for (int i = 0; i < 4; i++) begin
      eg = rr_pick(2'b11, mlast);
      send(2'b11, 1'b1, g, rdy, to);
      n_checks++;
      if (g !== eg || rdy !== (2'b01 << eg)) begin
        n_fail++;
        $display("FAIL arb_both_%0d: got %0d/%b want %0d", i, g, rdy, eg);
      end
      recv(0, id, res, fl, lat, to, st);
      r = alu_fn(m_op[eg], m_a[eg], m_b[eg]);
      mflags = flag_rule(mflags, m_op[eg], r);
      mlast = eg;
      n_checks++;
      if (res !== r[15:0] || fl !== mflags || id !== eg) begin
        n_fail++;
        $display("FAIL arb_resp_%0d: got %h %b id%0d want %h %b id%0d",
                 i, res, fl, id, r[15:0], mflags, eg);
      end
    end
    req_valid = 2'b00;
    send(2'b10, 1'b0, g, rdy, to);
    recv(0, id, res, fl, lat, to, st);
    r = alu_fn(m_op[1], m_a[1], m_b[1]);
    mflags = flag_rule(mflags, m_op[1], r);
    mlast = 1;
    n_checks++;
    if (g !== 1 || id !== 1) begin
      n_fail++; $display("FAIL arb_only1: got %0d/%0d want 1", g, id);
    end
    send(2'b11, 1'b0, g, rdy, to);
    recv(0, id, res, fl, lat, to, st);
    r = alu_fn(m_op[0], m_a[0], m_b[0]);
    mflags = flag_rule(mflags, m_op[0], r);
    mlast = 0;
    n_checks++;
    if (g !== 0 || id !== 0) begin
      n_fail++; $display("FAIL arb_then0: got %0d/%0d want 0", g, id);
    end
  endtask

  task automatic test_backpressure;
    int g, id, lat, eg;
    logic [1:0] rdy;
    logic [15:0] res;
    logic [2:0] fl;
    logic [17:0] r;
    bit to, st;
    set_req(0, 4'h1, 16'h0005, 16'h0007);
    set_req(1, 4'h1, 16'h0005, 16'h0007);
    eg = rr_pick(2'b11, mlast);
    send(2'b11, 1'b1, g, rdy, to);
    recv(5, id, res, fl, lat, to, st);
    req_valid = 2'b00;
    r = alu_fn(m_op[eg], m_a[eg], m_b[eg]);
    mflags = flag_rule(mflags, m_op[eg], r);
    mlast = eg;
    n_checks++;
    if (to || st !== 1'b1) begin
      n_fail++; $display("FAIL bp_stable: got %0d want 1", st);
    end
    n_checks++;
    if (id !== eg || res !== 16'hFFFE || fl !== mflags) begin
      n_fail++;
      $display("FAIL bp_resp: got id%0d %h %b want id%0d fffe %b",
               id, res, fl, eg, mflags);
    end
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got %b want 0", resp_valid);
    end
  endtask

  task automatic test_reset_mid;
    int g;
    logic [1:0] rdy;
    bit to, seen;
    set_req(0, 4'h1, 16'h8000, 16'h0001);
    send(2'b01, 1'b0, g, rdy, to);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mflags = 3'b000;
    mlast  = N - 1;
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || flags !== mflags) begin
      n_fail++;
      $display("FAIL rstmid_state: got %b %b want 0 000", resp_valid, flags);
    end
    n_checks++;
    if (resp_result !== 16'h0) begin
      n_fail++; $display("FAIL rstmid_result: got %h want 0000", resp_result);
    end
    seen = 1'b0;
    resp_ready = 2'b11;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    resp_ready = 2'b00;
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_no_resp: got %b want 0", seen);
    end
    req_valid = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== (2'b01 << rr_pick(2'b11, mlast))) begin
      n_fail++; $display("FAIL rstmid_grant: got %b want 01", req_ready);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_random;
    int g, id, lat, eg;
    logic [1:0] rdy, v;
    logic [15:0] res;
    logic [2:0] fl;
    logic [17:0] r;
    bit to, st;
    for (int i = 0; i < 40; i++) begin
      for (int q = 0; q < N; q++)
        set_req(q, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
      v  = 2'($urandom_range(1, 3));
      eg = rr_pick(v, mlast);
      send(v, 1'b0, g, rdy, to);
      recv($urandom_range(0, 3), id, res, fl, lat, to, st);
      r = alu_fn(m_op[eg], m_a[eg], m_b[eg]);
      mflags = flag_rule(mflags, m_op[eg], r);
      mlast = eg;
      n_checks++;
      if (to || g !== eg || id !== eg || lat !== 2 || st !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_hs_%0d: got g%0d id%0d lat%0d st%0d want %0d 2 1",
                 i, g, id, lat, st, eg);
      end
      n_checks++;
      if (res !== r[15:0] || fl !== mflags) begin
        n_fail++;
        $display("FAIL rand_data_%0d op%h: got %h %b want %h %b",
                 i, m_op[eg], res, fl, r[15:0], mflags);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    mflags     = '0;
    mlast      = N - 1;
    test_reset();
    test_add();
    test_flag_hold();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
